// File: rtl/ip_parser_if.sv
// IPv4 parser stream interface: Ethernet payload bytes in, IP payload bytes and header info out.
interface ip_parser_if;
  logic [7:0]  eth_data_out;
  logic        eth_byte_valid;
  logic        eth_eof;
  logic        eth_err;
  logic [7:0]  ip_data_out;
  logic        ip_byte_valid;
  logic        ip_eof;
  logic        ip_err;
  logic [31:0] ip_src_addr;
  logic [15:0] ip_payload_len;
  logic        ip_hdr_valid;

  modport master (
    output eth_data_out, eth_byte_valid, eth_eof, eth_err,
    input  ip_data_out, ip_byte_valid, ip_eof, ip_err, ip_src_addr, ip_payload_len, ip_hdr_valid
  );
  modport slave (
    input  eth_data_out, eth_byte_valid, eth_eof, eth_err,
    output ip_data_out, ip_byte_valid, ip_eof, ip_err, ip_src_addr, ip_payload_len, ip_hdr_valid
  );
endinterface

// File: rtl/ip_parser.sv
// IPv4 header parser: validates the header, forwards payload bytes, strips Ethernet padding.
// Optional header checksum verification is enabled by defining IP_CSUM_CHECK_EN.
module ip_parser #(
  parameter logic [7:0]  PROTOCOL = 8'h11,
  parameter logic [31:0] LOCAL_IP = 32'hC0A8_0164
) (
  input logic        clk,
  input logic        rst,
  ip_parser_if.slave bus
);
  typedef enum logic [1:0] {HEADER, PAYLOAD, PAD, DROP} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [3:0]  ver_q, ver_d, ihl_q, ihl_d;
  logic [15:0] tot_q, tot_d;
  logic [7:0]  proto_q, proto_d;
  logic [31:0] src_q, src_d, dst_q, dst_d;
  logic [15:0] rem_q, rem_d;
  logic [7:0]  data_q, data_d;
  logic        bv_q, bv_d, eof_q, eof_d, err_q, err_d, hv_q, hv_d;
  logic [31:0] src_out_q, src_out_d;
  logic [15:0] plen_q, plen_d;

  logic [5:0]  hdr_last;
  logic [15:0] hdr_len, plen_calc;
  logic        hdr_ok, csum_ok, frame_end;

  assign frame_end = bus.eth_eof | bus.eth_err;
  assign hdr_len   = {10'd0, ihl_q, 2'b00};
  // An IHL below 5 still runs through byte 19 so the failure is reported at a fixed point.
  assign hdr_last  = (ihl_q < 4'd5) ? 6'd19 : ({ihl_q, 2'b00} - 6'd1);
  assign plen_calc = tot_q - hdr_len;

`ifdef IP_CSUM_CHECK_EN
  logic [15:0] acc_q, acc_d, csum_fold;
  logic [7:0]  hi_q, hi_d;
  logic [16:0] csum_sum;
  logic        hdr_byte;

  assign hdr_byte = bus.eth_byte_valid && (state_q == HEADER);

  always_comb begin
    acc_d     = acc_q;
    hi_d      = hi_q;
    csum_sum  = {1'b0, acc_q} + {1'b0, hi_q, bus.eth_data_out};
    csum_fold = csum_sum[15:0] + {15'd0, csum_sum[16]};
    if (hdr_byte) begin
      if (cnt_q[0]) acc_d = csum_fold;
      else          hi_d  = bus.eth_data_out;
    end
    if (frame_end) begin
      acc_d = '0;
      hi_d  = '0;
    end
  end

  // The final word is folded in combinationally, so this is valid on the last header byte.
  assign csum_ok = (csum_fold == 16'hFFFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      hi_q  <= '0;
    end else begin
      acc_q <= acc_d;
      hi_q  <= hi_d;
    end
  end
`else
  assign csum_ok = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ver_d     = ver_q;
    ihl_d     = ihl_q;
    tot_d     = tot_q;
    proto_d   = proto_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    data_d    = data_q;
    bv_d      = 1'b0;
    eof_d     = 1'b0;
    err_d     = 1'b0;
    hv_d      = hv_q;
    src_out_d = src_out_q;
    plen_d    = plen_q;
    hdr_ok    = 1'b0;

    case (state_q)
      HEADER: if (bus.eth_byte_valid) begin
        cnt_d = cnt_q + 6'd1;
        case (cnt_q)
          6'd0:                     {ver_d, ihl_d} = bus.eth_data_out;
          6'd2:                     tot_d[15:8]    = bus.eth_data_out;
          6'd3:                     tot_d[7:0]     = bus.eth_data_out;
          6'd9:                     proto_d        = bus.eth_data_out;
          6'd12, 6'd13, 6'd14, 6'd15: src_d        = {src_q[23:0], bus.eth_data_out};
          6'd16, 6'd17, 6'd18, 6'd19: dst_d        = {dst_q[23:0], bus.eth_data_out};
          default: ;
        endcase
        if (cnt_q == hdr_last) begin
          hdr_ok = (ver_q == 4'd4) && (ihl_q >= 4'd5) && (proto_q == PROTOCOL) &&
                   (dst_d == LOCAL_IP) && (tot_q >= hdr_len) && csum_ok;
          if (hdr_ok) begin
            hv_d      = 1'b1;
            plen_d    = plen_calc;
            src_out_d = src_q;
            rem_d     = plen_calc;
            state_d   = (plen_calc == 16'd0) ? PAD : PAYLOAD;
          end else begin
            err_d   = 1'b1;
            state_d = DROP;
          end
        end
      end
      PAYLOAD: if (bus.eth_byte_valid) begin
        if (!bus.eth_err) begin
          data_d = bus.eth_data_out;
          bv_d   = 1'b1;
        end
        rem_d = rem_q - 16'd1;
        if (rem_q == 16'd1) state_d = PAD;
      end
      default: ;
    endcase

    // Frame end is judged on the state after this cycle's byte, so a byte completing the
    // payload together with eth_eof ends cleanly, and a header reject is never reported twice.
    if (frame_end) begin
      if (bus.eth_err) begin
        if (state_d != DROP) err_d = 1'b1;
      end else if (state_d == PAD) begin
        eof_d = 1'b1;
      end else if (state_d != DROP) begin
        err_d = 1'b1;
      end
      state_d = HEADER;
      cnt_d   = '0;
      rem_d   = '0;
      hv_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= HEADER;
      cnt_q     <= '0;
      ver_q     <= '0;
      ihl_q     <= '0;
      tot_q     <= '0;
      proto_q   <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      data_q    <= '0;
      bv_q      <= 1'b0;
      eof_q     <= 1'b0;
      err_q     <= 1'b0;
      hv_q      <= 1'b0;
      src_out_q <= '0;
      plen_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ver_q     <= ver_d;
      ihl_q     <= ihl_d;
      tot_q     <= tot_d;
      proto_q   <= proto_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rem_q     <= rem_d;
      data_q    <= data_d;
      bv_q      <= bv_d;
      eof_q     <= eof_d;
      err_q     <= err_d;
      hv_q      <= hv_d;
      src_out_q <= src_out_d;
      plen_q    <= plen_d;
    end
  end

  assign bus.ip_data_out    = data_q;
  assign bus.ip_byte_valid  = bv_q;
  assign bus.ip_eof         = eof_q;
  assign bus.ip_err         = err_q;
  assign bus.ip_src_addr    = src_out_q;
  assign bus.ip_payload_len = plen_q;
  assign bus.ip_hdr_valid   = hv_q;
endmodule
